fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the IF/ID pipeline register; it feeds that register's Instr1_IF / Instr_PC_IF / Instr_PC_Plus4_IF inputs.
- Owns the PC and drives a req/ack handshake to instruction memory.
- Absorbs downstream STALL with a one-entry hold buffer and honours branch-resolution redirects.
- Optionally predicts the next PC with a small BTB (2-bit counters).

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_btb.sv | 77 +++++++
 rtl/fetch_unit.sv | 221 ++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// 2-bit branch-predictor counter values, NOP word and default reset PC.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [1:0]  SNT = 2'b00;
    localparam logic [1:0]  WNT = 2'b01;
    localparam logic [1:0]  WT  = 2'b10;
    localparam logic [1:0]  ST  = 2'b11;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

    // Saturating step of a 2-bit direction counter
    function automatic logic [1:0] ctrNext(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'b01;
        end
        return (ctr == SNT) ? SNT : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is purely combinational on the current contents, so an update
// written in the same cycle is only seen by the following lookup.
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic        i_clk,
    input  logic        i_resetN,
    input  logic [31:0] i_lookupPc,
    output logic        o_hit,
    output logic        o_taken,
    output logic [31:0] o_target,
    input  logic        i_updValid,
    input  logic [31:0] i_updPc,
    input  logic        i_updTaken,
    input  logic [31:0] i_updTarget
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];

    logic [IDX_BITS-1:0] w_lookupIdx;
    logic [IDX_BITS-1:0] w_updIdx;
    logic [TAG_BITS-1:0] w_lookupTag;
    logic [TAG_BITS-1:0] w_updTag;
    logic                w_updHit;
    logic                w_unusedLowBits;

    assign w_lookupIdx = i_lookupPc[IDX_BITS+1:2];
    assign w_lookupTag = i_lookupPc[31:IDX_BITS+2];
    assign w_updIdx    = i_updPc[IDX_BITS+1:2];
    assign w_updTag    = i_updPc[31:IDX_BITS+2];

    assign o_hit    = r_valid[w_lookupIdx] && (r_tag[w_lookupIdx] == w_lookupTag);
    assign o_taken  = r_ctr[w_lookupIdx][1];
    assign o_target = r_target[w_lookupIdx];

    assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

    // Instruction addresses are word aligned; the byte offset never matters
    assign w_unusedLowBits = &{1'b0, i_lookupPc[1:0], i_updPc[1:0]};

    // Valid bits: cleared on reset, set when a taken miss allocates an entry
    always_ff @(posedge i_clk) begin
        if (!i_resetN) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (i_updValid && !w_updHit && i_updTaken) begin
            r_valid[w_updIdx] <= 1'b1;
        end
    end

    // Entry payload: train the counter on a hit, allocate on a taken miss
    always_ff @(posedge i_clk) begin
        if (i_resetN && i_updValid) begin
            if (w_updHit) begin
                r_ctr[w_updIdx] <= ctrNext(r_ctr[w_updIdx], i_updTaken);
                if (i_updTaken) begin
                    r_target[w_updIdx] <= i_updTarget;
                end
            end else if (i_updTaken) begin
                r_tag[w_updIdx]    <= w_updTag;
                r_ctr[w_updIdx]    <= WT;
                r_target[w_updIdx] <= i_updTarget;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, talks
// req/ack to instruction memory, parks one instruction while the pipe is
// stalled and follows redirects from branch resolution.
// Optional BTB-based next-PC prediction is enabled with `define FETCH_BTB_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          BTB_IDX_BITS = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    output logic        Imem_Req,
    output logic [31:0] Imem_Addr,
    input  logic        Imem_Ack,
    input  logic [31:0] Imem_Data,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF,
    output logic        Instr_Valid_IF,
    output logic        Pred_Taken_IF,
    input  logic        Bp_Update,
    input  logic [31:0] Bp_Update_PC,
    input  logic        Bp_Update_Taken,
    input  logic [31:0] Bp_Update_Target
);

    fetch_state_e r_state;
    fetch_state_e w_nextState;

    logic [31:0] r_pc;
    logic [31:0] r_drainAddr;
    logic [31:0] r_holdInstr;
    logic [31:0] r_holdPc;
    logic        r_holdPred;
    logic [31:0] r_instr;
    logic [31:0] r_instrPc;
    logic [31:0] r_instrPcPlus4;
    logic        r_valid;
    logic        r_predTaken;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_nextPc;
    logic        w_predTaken;
    logic        w_loadMem;
    logic        w_loadHold;
    logic        w_bubble;
    logic        w_captureHold;
    logic        w_captureDrain;
    logic        w_advancePc;

    assign w_pcPlus4 = r_pc + 32'd4;

`ifdef FETCH_BTB_EN
    logic        w_btbHit;
    logic        w_btbTaken;
    logic [31:0] w_btbTarget;

    fetch_btb #(
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .i_clk       (CLK),
        .i_resetN    (RESET),
        .i_lookupPc  (r_pc),
        .o_hit       (w_btbHit),
        .o_taken     (w_btbTaken),
        .o_target    (w_btbTarget),
        .i_updValid  (Bp_Update),
        .i_updPc     (Bp_Update_PC),
        .i_updTaken  (Bp_Update_Taken),
        .i_updTarget (Bp_Update_Target)
    );

    assign w_predTaken = w_btbHit & w_btbTaken;
    assign w_nextPc    = w_predTaken ? w_btbTarget : w_pcPlus4;
`else
    logic w_unusedBp;

    assign w_predTaken = 1'b0;
    assign w_nextPc    = w_pcPlus4;
    assign w_unusedBp  = &{1'b0, Bp_Update, Bp_Update_PC, Bp_Update_Taken,
                           Bp_Update_Target, BTB_IDX_BITS[0]};
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a redirect with a request still in flight must drain it
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FETCH: begin
                if (Request_Alt_PC) begin
                    w_nextState = Imem_Ack ? FETCH : DRAIN;
                end else if (Imem_Ack && STALL) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                if (Request_Alt_PC || !STALL) begin
                    w_nextState = FETCH;
                end
            end
            DRAIN: begin
                if (!Request_Alt_PC && Imem_Ack) begin
                    w_nextState = FETCH;
                end
            end
            default: w_nextState = FETCH;
        endcase
    end

    // Memory interface and datapath control decoded from state and inputs
    always_comb begin
        Imem_Req       = 1'b0;
        Imem_Addr      = r_pc;
        w_loadMem      = 1'b0;
        w_loadHold     = 1'b0;
        w_bubble       = 1'b0;
        w_captureHold  = 1'b0;
        w_captureDrain = 1'b0;
        w_advancePc    = 1'b0;
        case (r_state)
            FETCH: begin
                Imem_Req = 1'b1;
                if (Request_Alt_PC) begin
                    w_bubble       = 1'b1;
                    w_captureDrain = !Imem_Ack;
                end else if (Imem_Ack) begin
                    w_advancePc   = 1'b1;
                    w_captureHold = STALL;
                    w_loadMem     = !STALL;
                end else begin
                    w_bubble = !STALL;
                end
            end
            HOLD: begin
                if (Request_Alt_PC) begin
                    w_bubble = 1'b1;
                end else begin
                    w_loadHold = !STALL;
                end
            end
            DRAIN: begin
                Imem_Req  = 1'b1;
                Imem_Addr = r_drainAddr;
                w_bubble  = Request_Alt_PC || !STALL;
            end
            default: ;
        endcase
    end

    // Program counter and the address kept stable while draining
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_pc        <= RESET_PC;
            r_drainAddr <= 32'h0;
        end else begin
            if (Request_Alt_PC) begin
                r_pc <= Alt_PC;
            end else if (w_advancePc) begin
                r_pc <= w_nextPc;
            end
            if (w_captureDrain) begin
                r_drainAddr <= r_pc;
            end
        end
    end

    // One-entry hold buffer for an instruction that arrives during a stall
    always_ff @(posedge CLK) begin
        if (!RESET || Request_Alt_PC) begin
            r_holdInstr <= NOP;
            r_holdPc    <= 32'h0;
            r_holdPred  <= 1'b0;
        end else if (w_captureHold) begin
            r_holdInstr <= Imem_Data;
            r_holdPc    <= r_pc;
            r_holdPred  <= w_predTaken;
        end
    end

    // IF/ID-facing output registers: load, replay from hold, bubble or keep
    always_ff @(posedge CLK) begin
        if (!RESET || w_bubble) begin
            r_instr        <= NOP;
            r_instrPc      <= 32'h0;
            r_instrPcPlus4 <= 32'h0;
            r_valid        <= 1'b0;
            r_predTaken    <= 1'b0;
        end else if (w_loadMem) begin
            r_instr        <= Imem_Data;
            r_instrPc      <= r_pc;
            r_instrPcPlus4 <= w_pcPlus4;
            r_valid        <= 1'b1;
            r_predTaken    <= w_predTaken;
        end else if (w_loadHold) begin
            r_instr        <= r_holdInstr;
            r_instrPc      <= r_holdPc;
            r_instrPcPlus4 <= r_holdPc + 32'd4;
            r_valid        <= 1'b1;
            r_predTaken    <= r_holdPred;
        end
    end

    assign Instr1_IF         = r_instr;
    assign Instr_PC_IF       = r_instrPc;
    assign Instr_PC_Plus4_IF = r_instrPcPlus4;
    assign Instr_Valid_IF    = r_valid;
    assign Pred_Taken_IF     = r_predTaken;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/ack/redirect/predictor-update traffic, all compared every cycle
// against a transaction-level reference model. Honours `define FETCH_BTB_EN.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        Request_Alt_PC;
    logic [31:0] Alt_PC;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic        Imem_Ack;
    logic [31:0] Imem_Data;
    logic [31:0] Instr1_IF;
    logic [31:0] Instr_PC_IF;
    logic [31:0] Instr_PC_Plus4_IF;
    logic        Instr_Valid_IF;
    logic        Pred_Taken_IF;
    logic        Bp_Update;
    logic [31:0] Bp_Update_PC;
    logic        Bp_Update_Taken;
    logic [31:0] Bp_Update_Target;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .Request_Alt_PC    (Request_Alt_PC),
        .Alt_PC            (Alt_PC),
        .Imem_Req          (Imem_Req),
        .Imem_Addr         (Imem_Addr),
        .Imem_Ack          (Imem_Ack),
        .Imem_Data         (Imem_Data),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF),
        .Instr_Valid_IF    (Instr_Valid_IF),
        .Pred_Taken_IF     (Pred_Taken_IF),
        .Bp_Update         (Bp_Update),
        .Bp_Update_PC      (Bp_Update_PC),
        .Bp_Update_Taken   (Bp_Update_Taken),
        .Bp_Update_Target  (Bp_Update_Target)
    );

    localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;
    localparam logic [31:0] SCRAMBLE = 32'h5A5A_5A5A;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        pred;
    } outRec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } holdRec_t;

    int testCount = 0;
    int failCount = 0;

    // Reference model: architectural PC, parked instruction (at most one),
    // outstanding-request-to-discard flag and the visible output bundle.
    logic [31:0] m_pc;
    holdRec_t    m_holdQ[$];
    bit          m_draining;
    logic [31:0] m_drainAddr;
    outRec_t     m_out;
    bit          m_known = 1'b0;

`ifdef FETCH_BTB_EN
    bit          m_btbValid [16];
    logic [29:0] m_btbWord  [16];
    int          m_btbCtr   [16];
    logic [31:0] m_btbTarget[16];
`endif

    function automatic bit expReq();
        return (m_holdQ.size() == 0);
    endfunction

    function automatic logic [31:0] expAddr();
        return m_draining ? m_drainAddr : m_pc;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelLookup(input logic [31:0] pc, output bit taken, output logic [31:0] nxt);
        taken = 1'b0;
        nxt   = pc + 32'd4;
`ifdef FETCH_BTB_EN
        begin
            int idx;
            idx = int'(pc[5:2]);
            if (m_btbValid[idx] && m_btbWord[idx] == pc[31:2] && m_btbCtr[idx] >= 2) begin
                taken = 1'b1;
                nxt   = m_btbTarget[idx];
            end
        end
`endif
    endtask

    task automatic modelTrain(input bit bpu, input logic [31:0] bpPc, input bit bpTaken,
                              input logic [31:0] bpTgt);
`ifdef FETCH_BTB_EN
        int idx;
        idx = int'(bpPc[5:2]);
        if (bpu) begin
            if (m_btbValid[idx] && m_btbWord[idx] == bpPc[31:2]) begin
                if (bpTaken) begin
                    m_btbCtr[idx]    = (m_btbCtr[idx] < 3) ? m_btbCtr[idx] + 1 : 3;
                    m_btbTarget[idx] = bpTgt;
                end else begin
                    m_btbCtr[idx] = (m_btbCtr[idx] > 0) ? m_btbCtr[idx] - 1 : 0;
                end
            end else if (bpTaken) begin
                m_btbValid[idx]  = 1'b1;
                m_btbWord[idx]   = bpPc[31:2];
                m_btbCtr[idx]    = 2;
                m_btbTarget[idx] = bpTgt;
            end
        end
`else
        if (bpu && bpTaken && bpPc != bpTgt) begin
            m_known = m_known;
        end
`endif
    endtask

    task automatic modelStep(input bit rstN, input bit stall, input bit ack, input logic [31:0] data,
                             input bit redir, input logic [31:0] alt, input bit bpu,
                             input logic [31:0] bpPc, input bit bpTaken, input logic [31:0] bpTgt);
        bit          predTaken;
        logic [31:0] nxt;
        holdRec_t    entry;
        if (!rstN) begin
            m_pc        = BOOT_PC;
            m_holdQ.delete();
            m_draining  = 1'b0;
            m_drainAddr = 32'h0;
            m_out       = '0;
            m_known     = 1'b1;
`ifdef FETCH_BTB_EN
            for (int i = 0; i < 16; i++) m_btbValid[i] = 1'b0;
`endif
            return;
        end
        modelLookup(m_pc, predTaken, nxt);
        if (redir) begin
            if (m_holdQ.size() == 0 && !m_draining) begin
                m_draining  = !ack;
                m_drainAddr = m_pc;
            end
            m_holdQ.delete();
            m_pc  = alt;
            m_out = '0;
        end else if (m_holdQ.size() != 0) begin
            if (!stall) begin
                entry = m_holdQ.pop_front();
                m_out = '{entry.instr, entry.pc, entry.pc + 32'd4, 1'b1, entry.pred};
            end
        end else if (m_draining) begin
            if (ack) m_draining = 1'b0;
            if (!stall) m_out = '0;
        end else if (ack) begin
            entry = '{data, m_pc, predTaken};
            m_pc  = nxt;
            if (stall) m_holdQ.push_back(entry);
            else m_out = '{entry.instr, entry.pc, entry.pc + 32'd4, 1'b1, entry.pred};
        end else if (!stall) begin
            m_out = '0;
        end
        modelTrain(bpu, bpPc, bpTaken, bpTgt);
    endtask

    // One clock of stimulus: drive inputs, check the request side before the
    // edge, advance the model and check the registered outputs after it.
    task automatic applyStimulus(input bit rstN, input bit stall, input bit ack, input logic [31:0] data,
                                 input bit redir, input logic [31:0] alt, input bit bpu,
                                 input logic [31:0] bpPc, input bit bpTaken, input logic [31:0] bpTgt);
        RESET            = rstN;
        STALL            = stall;
        Imem_Ack         = ack;
        Imem_Data        = data;
        Request_Alt_PC   = redir;
        Alt_PC           = alt;
        Bp_Update        = bpu;
        Bp_Update_PC     = bpPc;
        Bp_Update_Taken  = bpTaken;
        Bp_Update_Target = bpTgt;
        #1;
        if (m_known) begin
            checkOutput("imem_req", {31'b0, Imem_Req}, {31'b0, expReq()});
            if (expReq()) checkOutput("imem_addr", Imem_Addr, expAddr());
        end
        @(posedge CLK);
        #1;
        modelStep(rstN, stall, ack, data, redir, alt, bpu, bpPc, bpTaken, bpTgt);
        checkOutput("instr", Instr1_IF, m_out.instr);
        checkOutput("instr_pc", Instr_PC_IF, m_out.pc);
        checkOutput("instr_pc4", Instr_PC_Plus4_IF, m_out.pc4);
        checkOutput("valid", {31'b0, Instr_Valid_IF}, {31'b0, m_out.valid});
        checkOutput("pred", {31'b0, Pred_Taken_IF}, {31'b0, m_out.pred});
    endtask

    task automatic fetchCycle(input bit stall, input bit ack, input logic [31:0] data);
        applyStimulus(1'b1, stall, ack, data, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redirectCycle(input bit ack, input logic [31:0] alt);
        applyStimulus(1'b1, 1'b0, ack, 32'hDEAD_BEEF, 1'b1, alt, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic bpCycle(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, taken, tgt);
    endtask

    initial begin
        // Reset held low for two cycles
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rst_valid", {31'b0, Instr_Valid_IF}, 32'd0);
        checkOutput("rst_instr", Instr1_IF, 32'h0);
        checkOutput("rst_req", {31'b0, Imem_Req}, 32'd1);
        checkOutput("rst_addr", Imem_Addr, BOOT_PC);

        // Back-to-back fetches
        fetchCycle(1'b0, 1'b1, BOOT_PC ^ SCRAMBLE);
        checkOutput("seq0_pc", Instr_PC_IF, 32'hBFC0_0000);
        checkOutput("seq0_pc4", Instr_PC_Plus4_IF, 32'hBFC0_0004);
        checkOutput("seq0_instr", Instr1_IF, 32'hE59A_5A5A);
        fetchCycle(1'b0, 1'b1, 32'hBFC0_0004 ^ SCRAMBLE);
        checkOutput("seq1_pc", Instr_PC_IF, 32'hBFC0_0004);

        // Ack during a three-cycle stall parks the instruction
        fetchCycle(1'b1, 1'b1, 32'h2402_000A);
        checkOutput("stall_frozen_pc", Instr_PC_IF, 32'hBFC0_0004);
        checkOutput("hold_req", {31'b0, Imem_Req}, 32'd0);
        fetchCycle(1'b1, 1'b0, 32'h0);
        fetchCycle(1'b1, 1'b0, 32'h0);
        fetchCycle(1'b0, 1'b0, 32'h0);
        checkOutput("release_instr", Instr1_IF, 32'h2402_000A);
        checkOutput("release_pc", Instr_PC_IF, 32'hBFC0_0008);
        checkOutput("release_addr", Imem_Addr, 32'hBFC0_000C);

        // Redirect while a request is outstanding
        fetchCycle(1'b0, 1'b1, 32'hBFC0_000C ^ SCRAMBLE);
        redirectCycle(1'b0, 32'h0040_0000);
        checkOutput("drain_addr0", Imem_Addr, 32'hBFC0_0010);
        fetchCycle(1'b0, 1'b0, 32'h0);
        checkOutput("drain_addr1", Imem_Addr, 32'hBFC0_0010);
        fetchCycle(1'b0, 1'b1, 32'hCAFE_F00D);
        checkOutput("drain_drop_valid", {31'b0, Instr_Valid_IF}, 32'd0);
        checkOutput("drain_new_addr", Imem_Addr, 32'h0040_0000);

        // PC+4 wraps at the top of the address space
        redirectCycle(1'b1, 32'hFFFF_FFFC);
        fetchCycle(1'b0, 1'b1, 32'h1234_5678);
        checkOutput("wrap_pc4", Instr_PC_Plus4_IF, 32'h0000_0000);
        checkOutput("wrap_next_addr", Imem_Addr, 32'h0000_0000);

        // Predictor training and use
        bpCycle(32'h0040_0020, 1'b1, 32'h0040_0100);
        redirectCycle(1'b1, 32'h0040_0020);
        fetchCycle(1'b0, 1'b1, 32'h1000_0003);
`ifdef FETCH_BTB_EN
        checkOutput("btb_pred_taken", {31'b0, Pred_Taken_IF}, 32'd1);
        checkOutput("btb_target_addr", Imem_Addr, 32'h0040_0100);
`else
        checkOutput("btb_pred_off", {31'b0, Pred_Taken_IF}, 32'd0);
        checkOutput("btb_seq_addr", Imem_Addr, 32'h0040_0024);
`endif
        bpCycle(32'h0040_0020, 1'b0, 32'h0);
        bpCycle(32'h0040_0020, 1'b0, 32'h0);
        redirectCycle(1'b1, 32'h0040_0020);
        fetchCycle(1'b0, 1'b1, 32'h1000_0003);
        checkOutput("btb_untrained_pred", {31'b0, Pred_Taken_IF}, 32'd0);
        checkOutput("btb_untrained_addr", Imem_Addr, 32'h0040_0024);

        // Reset arriving while an instruction is parked
        fetchCycle(1'b1, 1'b1, 32'h0BAD_0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("hold_rst_valid", {31'b0, Instr_Valid_IF}, 32'd0);
        checkOutput("hold_rst_req", {31'b0, Imem_Req}, 32'd1);
        checkOutput("hold_rst_addr", Imem_Addr, BOOT_PC);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit          rstN;
            bit          stall;
            bit          ack;
            bit          redir;
            bit          bpu;
            bit          bpTaken;
            logic [31:0] alt;
            logic [31:0] bpPc;
            logic [31:0] bpTgt;
            rstN    = ($urandom_range(0, 99) >= 2);
            stall   = ($urandom_range(0, 99) < 30);
            ack     = expReq() && ($urandom_range(0, 99) < 60);
            redir   = ($urandom_range(0, 99) < 8);
            bpu     = ($urandom_range(0, 99) < 20);
            bpTaken = ($urandom_range(0, 1) == 1);
            alt     = 32'h0040_0000 | 32'($urandom_range(0, 31) << 2);
            bpPc    = 32'h0040_0000 | 32'($urandom_range(0, 31) << 2);
            bpTgt   = 32'h0040_0000 | 32'($urandom_range(0, 31) << 2);
            applyStimulus(rstN, stall, ack, expAddr() ^ SCRAMBLE, redir, alt, bpu, bpPc, bpTaken, bpTgt);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
